// File: rtl/lsm_dispatch_sequencer.sv
// Function-table registry plus lifecycle sequencer for NUM_LSM land-surface-model engines.
// Latency: first call presented on the second cycle after start is sampled; one call in flight at a time.
// Backpressure: each call holds in ISSUE until call_ready; registration is accepted only while idle.
module lsm_dispatch_sequencer #(
    parameter int NUM_LSM      = 4,
    parameter int HANDLE_W     = 16,
    parameter int STEP_W       = 16,
    parameter int RST_INTERVAL = 24,
    localparam int LSM_W       = (NUM_LSM > 1) ? $clog2(NUM_LSM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_valid,
    output logic                reg_ready,
    input  logic [LSM_W-1:0]    reg_lsm,
    input  logic [2:0]          reg_op,
    input  logic [HANDLE_W-1:0] reg_handle,
    input  logic                start,
    input  logic [LSM_W-1:0]    start_lsm,
    input  logic                cold_start,
    input  logic [STEP_W-1:0]   num_steps,
    input  logic                abort,
    output logic                call_valid,
    input  logic                call_ready,
    output logic [2:0]          call_op,
    output logic [HANDLE_W-1:0] call_handle,
    output logic [STEP_W-1:0]   call_step,
    input  logic                call_done,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status
);
    localparam int SLOTS = NUM_LSM * 8;
    localparam int RC_W  = (RST_INTERVAL > 1) ? $clog2(RST_INTERVAL) : 1;

    localparam logic [2:0] OP_INI = 3'd0, OP_SETUP = 3'd1, OP_DYN = 3'd2, OP_F2T = 3'd3;
    localparam logic [2:0] OP_RUN = 3'd4, OP_OUT = 3'd5, OP_RESTART = 3'd6, OP_WRST = 3'd7;
    localparam logic [1:0] ST_OK = 2'b00, ST_UNREG = 2'b01, ST_ABORT = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_WAIT, S_ADVANCE, S_FINISH} state_t;

    state_t                state, state_d;
    logic [LSM_W-1:0]      lsm_q;
    logic                  cold_q;
    logic [STEP_W-1:0]     nsteps_q;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [2:0]            op_q, op_d;
    logic [RC_W-1:0]       rcnt_q, rcnt_d;
    logic [HANDLE_W-1:0]   handle_q;
    logic [1:0]            status_q, status_d;
    logic                  abort_q;
    logic                  load_cfg, load_handle;
    logic [SLOTS-1:0]      slot_vld;
    logic [HANDLE_W-1:0]   handle_mem [SLOTS];

    logic                  reg_fire, reg_in_range, lsm_in_range, slot_hit, abort_now;
    logic                  is_last, rst_hit, no_steps, seq_end;
    logic [LSM_W+2:0]      reg_idx, cur_idx;
    logic [RC_W-1:0]       rcnt_inc;

    assign reg_idx      = {reg_lsm, reg_op};
    assign cur_idx      = {lsm_q, op_q};
    assign reg_in_range = int'(reg_lsm) < NUM_LSM;
    assign lsm_in_range = int'(lsm_q) < NUM_LSM;
    assign reg_fire     = reg_valid && (state == S_IDLE);
    assign reg_ready    = reg_fire;
    assign slot_hit     = lsm_in_range && slot_vld[cur_idx];
    assign abort_now    = abort_q || abort;
    // Widened add so the last-step compare never wraps at the top of the step range.
    assign is_last      = ({1'b0, step_q} + {{STEP_W{1'b0}}, 1'b1}) == {1'b0, nsteps_q};
    assign rst_hit      = rcnt_q == RC_W'(RST_INTERVAL - 1);
    assign rcnt_inc     = rst_hit ? '0 : rcnt_q + 1'b1;
    assign no_steps     = nsteps_q == '0;

    assign call_valid   = (state == S_ISSUE);
    assign call_op      = op_q;
    assign call_handle  = handle_q;
    assign call_step    = step_q;
    assign busy         = (state != S_IDLE) && (state != S_FINISH);
    assign done         = (state == S_FINISH);
    assign status       = status_q;

    // Registry valid bits: set on accepted registration, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
        end else if (reg_fire && reg_in_range) begin
            slot_vld[reg_idx] <= 1'b1;
        end
    end

    // Handle storage needs no reset; a slot is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (reg_fire && reg_in_range) begin
            handle_mem[reg_idx] <= reg_handle;
        end
    end

    // State register and sequencing context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lsm_q    <= '0;
            cold_q   <= 1'b0;
            nsteps_q <= '0;
            step_q   <= '0;
            op_q     <= '0;
            rcnt_q   <= '0;
            handle_q <= '0;
            status_q <= ST_OK;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_d;
            step_q   <= step_d;
            op_q     <= op_d;
            rcnt_q   <= rcnt_d;
            status_q <= status_d;
            if (load_cfg) begin
                lsm_q    <= start_lsm;
                cold_q   <= cold_start;
                nsteps_q <= num_steps;
            end
            if (load_handle) begin
                handle_q <= handle_mem[cur_idx];
            end
            if (state == S_FINISH) begin
                abort_q <= 1'b0;
            end else if (busy && abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    // Next-state, next-op and completion status.
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        step_d      = step_q;
        rcnt_d      = rcnt_q;
        status_d    = status_q;
        load_cfg    = 1'b0;
        load_handle = 1'b0;
        seq_end     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOOKUP;
                    op_d     = OP_INI;
                    step_d   = '0;
                    rcnt_d   = '0;
                    status_d = ST_OK;
                    load_cfg = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (!slot_hit) begin
                    status_d = ST_UNREG;
                    state_d  = S_FINISH;
                end else if (abort_now) begin
                    status_d = ST_ABORT;
                    state_d  = S_FINISH;
                end else begin
                    load_handle = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An accepted call takes priority over a coincident abort.
                if (call_ready) begin
                    state_d = S_WAIT;
                end else if (abort_now) begin
                    status_d = ST_ABORT;
                    state_d  = S_FINISH;
                end
            end
            S_WAIT: begin
                if (call_done) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (abort_now) begin
                    status_d = ST_ABORT;
                    state_d  = S_FINISH;
                end else begin
                    case (op_q)
                        OP_INI:     op_d = OP_SETUP;
                        OP_SETUP: begin
                            if (!cold_q)       op_d = OP_RESTART;
                            else if (no_steps) seq_end = 1'b1;
                            else               op_d = OP_DYN;
                        end
                        OP_RESTART: begin
                            if (no_steps) seq_end = 1'b1;
                            else          op_d = OP_DYN;
                        end
                        OP_DYN:     op_d = OP_F2T;
                        OP_F2T:     op_d = OP_RUN;
                        OP_RUN:     op_d = OP_OUT;
                        OP_OUT: begin
                            if (rst_hit || is_last) begin
                                op_d = OP_WRST;
                            end else begin
                                op_d   = OP_DYN;
                                step_d = step_q + 1'b1;
                                rcnt_d = rcnt_inc;
                            end
                        end
                        default: begin
                            if (is_last) begin
                                seq_end = 1'b1;
                            end else begin
                                op_d   = OP_DYN;
                                step_d = step_q + 1'b1;
                                rcnt_d = rcnt_inc;
                            end
                        end
                    endcase
                    if (seq_end) begin
                        status_d = ST_OK;
                        state_d  = S_FINISH;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end
endmodule
